io_display_ctrl: RTL

IO_DISPLAY_CTRL -- requirements
Module: io_display_ctrl

---
 rtl/io_display_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/io_display_ctrl.sv
// Memory-mapped LED / 7-seg / blink register block with one-cycle io_ack.
// Optional feature: define BLINK_TIMER_EN to make blinking self-terminate after blink_ms ticks.
module io_display_ctrl #(
   parameter int unsigned TICK_CYCLES = 100_000,
   parameter logic [31:0] LED_ADDR    = 32'hFFFF_FC60,
   parameter logic [31:0] SEG_ADDR    = 32'hFFFF_FC70,
   parameter logic [31:0] BLINK_ADDR  = 32'hFFFF_FC80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_wen,
   input  logic        io_ren,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        io_ack,
   output logic [23:0] data_display,
   output logic [23:0] led_display,
   output logic        blink_need
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } blink_state_t;

   blink_state_t state, state_nx;

   logic        hit_led, hit_seg, hit_blink, hit_any;
   logic        access, blink_wr;
   logic [15:0] blink_val;
   logic [15:0] blink_rd;
   logic [31:0] rd_next;

   assign hit_led   = (io_addr[31:2] == LED_ADDR[31:2]);
   assign hit_seg   = (io_addr[31:2] == SEG_ADDR[31:2]);
   assign hit_blink = (io_addr[31:2] == BLINK_ADDR[31:2]);
   assign hit_any   = hit_led | hit_seg | hit_blink;
   assign access    = (io_wen | io_ren) & hit_any;
   assign blink_wr  = io_wen & hit_blink;
   assign blink_val = io_wdata[15:0];

   // A load is only honoured when no store shares the cycle; otherwise rdata stays 0.
   always_comb begin
      rd_next = '0;
      if (io_ren && !io_wen) begin
         if (hit_led)
            rd_next = {8'h00, led_display};
         else if (hit_seg)
            rd_next = {8'h00, data_display};
         else if (hit_blink)
            rd_next = {16'h0000, blink_rd};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io_ack       <= 1'b0;
         io_rdata     <= '0;
         led_display  <= '0;
         data_display <= '0;
      end else begin
         io_ack   <= access;
         io_rdata <= rd_next;
         if (io_wen && hit_led)
            led_display <= io_wdata[23:0];
         if (io_wen && hit_seg)
            data_display <= io_wdata[23:0];
      end
   end

   assign blink_need = (state == ACTIVE);

`ifdef BLINK_TIMER_EN
   localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

   logic [TW-1:0] tick_cnt, tick_nx;
   logic [15:0]   ms_cnt, ms_nx;

   // Any BLINK store restarts the period; the last tick of the last ms drops to IDLE.
   always_comb begin
      state_nx = state;
      tick_nx  = tick_cnt;
      ms_nx    = ms_cnt;
      if (blink_wr) begin
         tick_nx = '0;
         if (blink_val != '0) begin
            state_nx = ACTIVE;
            ms_nx    = blink_val;
         end else begin
            state_nx = IDLE;
            ms_nx    = '0;
         end
      end else if (state == ACTIVE) begin
         if (tick_cnt == TICK_LAST) begin
            tick_nx = '0;
            ms_nx   = ms_cnt - 16'd1;
            if (ms_cnt == 16'd1)
               state_nx = IDLE;
         end else begin
            tick_nx = tick_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         ms_cnt   <= '0;
      end else begin
         state    <= state_nx;
         tick_cnt <= tick_nx;
         ms_cnt   <= ms_nx;
      end
   end

   assign blink_rd = ms_cnt;
`else
   logic [15:0] blink_ms;

   always_comb begin
      state_nx = state;
      if (blink_wr)
         state_nx = (blink_val != '0) ? ACTIVE : IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         blink_ms <= '0;
      end else begin
         state <= state_nx;
         if (blink_wr)
            blink_ms <= blink_val;
      end
   end

   assign blink_rd = blink_ms;
`endif

endmodule
